// File: rtl/ram_march_bist.sv
// ram_march_bist
// Built-in self-test initiator for a dual-port RAM. It owns the RAM write and
// read ports while busy. It runs a four-phase march sweep:
//   W0_UP  write P, ascending
//   R0_UP  read and expect P, ascending
//   DRN0   drain
//   W1_DN  write ~P, descending
//   R1_DN  read and expect ~P, descending
//   DRN1   drain
// Read data is compared in a pipeline that is RD_LAT stages deep.
//
// Ports
//   clk, resetn        clock (rising edge); asynchronous active-low reset
//   start              begin a test; only accepted in IDLE or DONE
//   busy, done         sweep running / sweep finished (done held until next start)
//   fail, fail_count   sticky mismatch flag and saturating mismatch count
//   ram_write, ram_wr_address, ram_data_in   RAM write port
//   ram_read, ram_rd_address, ram_data_out   RAM read port (data RD_LAT after read)
//   err_addr, err_exp, err_act               first-failure capture
//
// Optional feature: define BIST_ERR_CAPTURE_EN to latch the address, the
// expected data and the actual data of the first mismatch after each start.
// When it is not defined, the err_* outputs are tied to zero.

module ram_march_bist #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1,
  parameter logic [DATA_W-1:0] PATTERN = 64'hAAAA_AAAA_AAAA_AAAA
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [15:0]       fail_count,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_wr_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_rd_address,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_exp,
  output logic [DATA_W-1:0] err_act
);

  typedef enum logic [2:0] {
    IDLE, W0_UP, R0_UP, DRN0, W1_DN, R1_DN, DRN1, DONE
  } state_t;

  state_t state;
  logic [2:0] drn_cnt;
  logic pipe_v [RD_LAT];
  logic [DATA_W-1:0] pipe_exp [RD_LAT];
  logic mismatch;
  logic start_ok;

  assign start_ok = start && (state == IDLE || state == DONE);
  assign mismatch = pipe_v[RD_LAT-1] && (ram_data_out != pipe_exp[RD_LAT-1]);

  // The sequencer and the compare pipeline share one clocked block. The
  // expected value is set from the state that issued the read. State, strobes
  // and addresses change together, so they always stay aligned.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      drn_cnt        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      fail           <= 1'b0;
      fail_count     <= '0;
      ram_write      <= 1'b0;
      ram_wr_address <= '0;
      ram_data_in    <= '0;
      ram_read       <= 1'b0;
      ram_rd_address <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_exp[i] <= '0;
      end
    end else begin
      pipe_v[0]   <= ram_read;
      pipe_exp[0] <= (state == R1_DN) ? ~PATTERN : PATTERN;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_exp[i] <= pipe_exp[i-1];
      end

      if (mismatch) begin
        fail <= 1'b1;
        if (fail_count != 16'hFFFF)
          fail_count <= fail_count + 16'd1;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= W0_UP;
            busy           <= 1'b1;
            done           <= 1'b0;
            fail           <= 1'b0;
            fail_count     <= '0;
            ram_write      <= 1'b1;
            ram_wr_address <= '0;
            ram_data_in    <= PATTERN;
          end
        end
        W0_UP: begin
          if (ram_wr_address == '1) begin
            state          <= R0_UP;
            ram_write      <= 1'b0;
            ram_read       <= 1'b1;
            ram_rd_address <= '0;
          end else begin
            ram_wr_address <= ram_wr_address + 1'b1;
          end
        end
        R0_UP: begin
          if (ram_rd_address == '1) begin
            state    <= DRN0;
            ram_read <= 1'b0;
            drn_cnt  <= '0;
          end else begin
            ram_rd_address <= ram_rd_address + 1'b1;
          end
        end
        DRN0: begin
          if (drn_cnt == 3'(RD_LAT - 1)) begin
            state          <= W1_DN;
            ram_write      <= 1'b1;
            ram_wr_address <= '1;
            ram_data_in    <= ~PATTERN;
          end else begin
            drn_cnt <= drn_cnt + 3'd1;
          end
        end
        W1_DN: begin
          if (ram_wr_address == '0) begin
            state          <= R1_DN;
            ram_write      <= 1'b0;
            ram_read       <= 1'b1;
            ram_rd_address <= '1;
          end else begin
            ram_wr_address <= ram_wr_address - 1'b1;
          end
        end
        R1_DN: begin
          if (ram_rd_address == '0) begin
            state    <= DRN1;
            ram_read <= 1'b0;
            drn_cnt  <= '0;
          end else begin
            ram_rd_address <= ram_rd_address - 1'b1;
          end
        end
        DRN1: begin
          // The last compare lands on this same edge, so fail is final when done rises.
          if (drn_cnt == 3'(RD_LAT - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drn_cnt <= drn_cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BIST_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] pipe_addr [RD_LAT];

  // The read address travels alongside the compare pipeline. While fail is
  // still low, the current mismatch is the first one since the last start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_addr <= '0;
      err_exp  <= '0;
      err_act  <= '0;
      for (int i = 0; i < RD_LAT; i++)
        pipe_addr[i] <= '0;
    end else begin
      pipe_addr[0] <= ram_rd_address;
      for (int i = 1; i < RD_LAT; i++)
        pipe_addr[i] <= pipe_addr[i-1];
      if (start_ok) begin
        err_addr <= '0;
        err_exp  <= '0;
        err_act  <= '0;
      end else if (mismatch && !fail) begin
        err_addr <= pipe_addr[RD_LAT-1];
        err_exp  <= pipe_exp[RD_LAT-1];
        err_act  <= ram_data_out;
      end
    end
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign err_addr = '0;
  assign err_exp  = '0;
  assign err_act  = '0;
`endif

endmodule
